// File: rtl/reorder_buffer_cdb_if.sv
// Purpose: bundles dispatch, CDB and commit signals between the core and the reorder buffer.
// Latency: none, this is wiring only; timing belongs to the buffer itself.
// Backpressure: dispatch is throttled by allocAccept; the CDB and commit sides cannot be stalled.
interface reorder_buffer_cdb_if #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2
);
  // CDB broadcast from the arbiter (registered on its side)
  logic           cdbValid;
  logic [ROB:0]   cdbRobEntry;
  logic [WIDTH:0] cdbResult;
  logic           cdbIsControl;
  logic [WIDTH:0] cdbTargetAddress;

  // Dispatch allocation request and response
  logic           allocReq;
  logic [4:0]     allocDestReg;
  logic           allocIsControl;
  logic [WIDTH:0] allocPredTarget;
  logic           allocAccept;
  logic [ROB:0]   allocRob;
  logic           full;
  logic           empty;

  // Retirement towards the register file and fetch redirect
  logic           commitValid;
  logic [ROB:0]   commitRob;
  logic [4:0]     commitDestReg;
  logic [WIDTH:0] commitValue;
  logic           commitWe;
  logic           flush;
  logic [WIDTH:0] redirectAddress;

  // Core side: drives dispatch and CDB, observes retirement
  modport master (
    output cdbValid, cdbRobEntry, cdbResult, cdbIsControl, cdbTargetAddress,
    output allocReq, allocDestReg, allocIsControl, allocPredTarget,
    input  allocAccept, allocRob, full, empty,
    input  commitValid, commitRob, commitDestReg, commitValue, commitWe,
    input  flush, redirectAddress
  );

  // Reorder buffer side
  modport slave (
    input  cdbValid, cdbRobEntry, cdbResult, cdbIsControl, cdbTargetAddress,
    input  allocReq, allocDestReg, allocIsControl, allocPredTarget,
    output allocAccept, allocRob, full, empty,
    output commitValid, commitRob, commitDestReg, commitValue, commitWe,
    output flush, redirectAddress
  );
endinterface

// File: rtl/reorder_buffer_cdb.sv
// Purpose: in-order commit buffer that consumes CDB broadcasts and retires one entry per cycle.
// Latency: CDB at edge E marks ready; commit outputs register at E+1 at the earliest.
// Backpressure: allocAccept drops when full (before same-cycle commit) or while a flush is taken.
module reorder_buffer_cdb #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2
) (
  input  logic                 clk,
  input  logic                 resetN,
  reorder_buffer_cdb_if.slave  bus
);

  localparam int DEPTH = 2 ** (ROB + 1);
  localparam int CW    = ROB + 2;

  typedef logic [ROB:0] tag_t;

  // Control state, cleared by reset and by flush
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] mispredict;
  tag_t             head;
  tag_t             tail;
  logic [CW-1:0]    count;

  // Payload state; only meaningful while the matching busy bit is set
  logic [DEPTH-1:0] is_control;
  logic [4:0]       dest_reg [DEPTH];
  logic [WIDTH:0]   value    [DEPTH];
  logic [WIDTH:0]   target   [DEPTH];

  logic full_now;
  logic empty_now;
  logic head_done;
  logic commit_now;
  logic flush_now;
  logic alloc_accept;
  logic cdb_hit;
  logic cdb_ctrl_match;
  tag_t cdb_tag;

  assign cdb_tag = bus.cdbRobEntry;

  // Head retirement decision, allocation gate and CDB acceptance, all from registered state
  always_comb begin
    full_now       = (count == CW'(DEPTH));
    empty_now      = (count == '0);
    head_done      = busy[head] & ready[head];
    commit_now     = head_done & ~mispredict[head];
    flush_now      = head_done & mispredict[head];
    alloc_accept   = bus.allocReq & ~full_now & ~flush_now;
    cdb_hit        = bus.cdbValid & busy[cdb_tag] & ~flush_now;
    cdb_ctrl_match = cdb_hit & is_control[cdb_tag] & bus.cdbIsControl;
  end

  assign bus.allocAccept = alloc_accept;
  assign bus.allocRob    = tail;
  assign bus.full        = full_now;
  assign bus.empty       = empty_now;

  // Pointers, per-entry status bits and registered commit/flush outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      busy                <= '0;
      ready               <= '0;
      mispredict          <= '0;
      head                <= '0;
      tail                <= '0;
      count               <= '0;
      bus.commitValid     <= 1'b0;
      bus.commitRob       <= '0;
      bus.commitDestReg   <= '0;
      bus.commitValue     <= '0;
      bus.commitWe        <= 1'b0;
      bus.flush           <= 1'b0;
      bus.redirectAddress <= '0;
    end else if (flush_now) begin
      // The mispredicted head still retires its link value, then everything younger is dropped
      bus.commitValid     <= 1'b1;
      bus.commitRob       <= head;
      bus.commitDestReg   <= dest_reg[head];
      bus.commitValue     <= value[head];
      bus.commitWe        <= (dest_reg[head] != 5'd0);
      bus.flush           <= 1'b1;
      bus.redirectAddress <= target[head];
      busy                <= '0;
      ready               <= '0;
      mispredict          <= '0;
      head                <= '0;
      tail                <= '0;
      count               <= '0;
    end else begin
      bus.flush       <= 1'b0;
      bus.commitValid <= commit_now;
      bus.commitWe    <= commit_now & (dest_reg[head] != 5'd0);
      if (commit_now) begin
        bus.commitRob     <= head;
        bus.commitDestReg <= dest_reg[head];
        bus.commitValue   <= value[head];
        busy[head]        <= 1'b0;
        head              <= head + tag_t'(1);
      end
      // A control result only flags a mispredict when both sides agree it is control flow
      if (cdb_hit) begin
        ready[cdb_tag] <= 1'b1;
        if (cdb_ctrl_match) begin
          mispredict[cdb_tag] <= (bus.cdbTargetAddress != target[cdb_tag]);
        end
      end
      // The tail slot is never busy when accepted, so it cannot collide with the CDB or head
      if (alloc_accept) begin
        busy[tail]       <= 1'b1;
        ready[tail]      <= 1'b0;
        mispredict[tail] <= 1'b0;
        tail             <= tail + tag_t'(1);
      end
      count <= count + CW'(alloc_accept) - CW'(commit_now);
    end
  end

  // Payload capture; the resolved target overwrites the predicted one so it can drive redirect
  always_ff @(posedge clk) begin
    if (cdb_hit) begin
      value[cdb_tag] <= bus.cdbResult;
      if (cdb_ctrl_match) begin
        target[cdb_tag] <= bus.cdbTargetAddress;
      end
    end
    if (alloc_accept) begin
      is_control[tail] <= bus.allocIsControl;
      dest_reg[tail]   <= bus.allocDestReg;
      target[tail]     <= bus.allocPredTarget;
    end
  end

endmodule

// File: tb/tb_reorder_buffer_cdb.sv
// Purpose: self-checking bench for reorder_buffer_cdb with a commit-order scoreboard.
// Latency: inputs driven 1 ns after a rising edge, outputs sampled 1 ns after the next edge.
// Backpressure: expected allocAccept is given per vector and compared before each edge.
module tb_reorder_buffer_cdb;

  logic clk;
  logic resetN;

  reorder_buffer_cdb_if #(.WIDTH(31), .ROB(2)) bus ();

  reorder_buffer_cdb #(.WIDTH(31), .ROB(2)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        areq;
    logic [4:0]  adest;
    logic        actl;
    logic [31:0] apred;
    logic        exp_acc;
    logic        cv;
    logic [2:0]  ctag;
    logic [31:0] cres;
    logic        cctl;
    logic [31:0] ctgt;
    logic        exp_cv;
    logic        exp_flush;
    logic        exp_empty;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Scoreboard: tags in program order, with dest and value recorded as stimulus is driven
  logic [2:0]  sb_q [$];
  logic [2:0]  exp_tail;
  logic [4:0]  m_dest [8];
  logic [31:0] m_val  [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pending(input logic [2:0] tag);
    foreach (sb_q[i]) if (sb_q[i] == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic vec_t mk(input logic areq, input logic [4:0] adest, input logic actl,
                              input logic [31:0] apred, input logic eacc, input logic cv,
                              input logic [2:0] ctag, input logic [31:0] cres, input logic cctl,
                              input logic [31:0] ctgt, input logic ecv, input logic ef,
                              input logic ee);
    vec_t v;
    v = '{areq, adest, actl, apred, eacc, cv, ctag, cres, cctl, ctgt, ecv, ef, ee};
    return v;
  endfunction

  function automatic vec_t idle(input logic ecv, input logic ef, input logic ee);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ecv, ef, ee);
  endfunction

  function automatic vec_t alloc(input logic [4:0] d, input logic eacc, input logic ecv,
                                 input logic ee);
    return mk(1, d, 0, 0, eacc, 0, 0, 0, 0, 0, ecv, 0, ee);
  endfunction

  function automatic vec_t cdb(input logic [2:0] t, input logic [31:0] r, input logic ecv,
                               input logic ee);
    return mk(0, 0, 0, 0, 0, 1, t, r, 0, 0, ecv, 0, ee);
  endfunction

  task automatic clear_model();
    sb_q.delete();
    exp_tail = 3'd0;
  endtask

  // One clock cycle: drive, check the allocation response, clock, then check retirement
  task automatic step(input vec_t v, input string name);
    logic [2:0] t;
    bus.allocReq         = v.areq;
    bus.allocDestReg     = v.adest;
    bus.allocIsControl   = v.actl;
    bus.allocPredTarget  = v.apred;
    bus.cdbValid         = v.cv;
    bus.cdbRobEntry      = v.ctag;
    bus.cdbResult        = v.cres;
    bus.cdbIsControl     = v.cctl;
    bus.cdbTargetAddress = v.ctgt;
    #1;
    if (v.areq) begin
      chk({name, " allocAccept"}, 32'(bus.allocAccept), 32'(v.exp_acc));
      if (v.exp_acc) chk({name, " allocRob"}, 32'(bus.allocRob), 32'(exp_tail));
    end
    if (v.cv && pending(v.ctag)) m_val[v.ctag] = v.cres;
    if (v.areq && v.exp_acc) begin
      sb_q.push_back(exp_tail);
      m_dest[exp_tail] = v.adest;
      m_val[exp_tail]  = 32'hBAD0_0000 | 32'(exp_tail);
      exp_tail         = exp_tail + 3'd1;
    end
    @(posedge clk);
    #1;
    bus.allocReq = 1'b0;
    bus.cdbValid = 1'b0;
    chk({name, " commitValid"}, 32'(bus.commitValid), 32'(v.exp_cv));
    chk({name, " flush"}, 32'(bus.flush), 32'(v.exp_flush));
    chk({name, " empty"}, 32'(bus.empty), 32'(v.exp_empty));
    if (bus.commitValid) begin
      if (sb_q.size() == 0) begin
        chk({name, " unexpected commit rob"}, 32'(bus.commitRob), 32'hFFFF_FFFF);
      end else begin
        t = sb_q.pop_front();
        chk({name, " commitRob"}, 32'(bus.commitRob), 32'(t));
        chk({name, " commitDestReg"}, 32'(bus.commitDestReg), 32'(m_dest[t]));
        chk({name, " commitValue"}, bus.commitValue, m_val[t]);
        chk({name, " commitWe"}, 32'(bus.commitWe), 32'(m_dest[t] != 5'd0));
      end
    end
    if (v.exp_flush) clear_model();
  endtask

  // Asserts reset mid-cycle, checks the outputs clear at once, then releases it
  task automatic do_reset(input string name);
    resetN = 1'b0;
    #1;
    chk({name, " empty in reset"}, 32'(bus.empty), 32'd1);
    chk({name, " full in reset"}, 32'(bus.full), 32'd0);
    chk({name, " commitValid in reset"}, 32'(bus.commitValid), 32'd0);
    chk({name, " commitWe in reset"}, 32'(bus.commitWe), 32'd0);
    chk({name, " flush in reset"}, 32'(bus.flush), 32'd0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    #1;
    chk({name, " allocRob after release"}, 32'(bus.allocRob), 32'(exp_tail));
  endtask

  vec_t tbl [13];

  initial begin
    // Out-of-order completion, then a correctly predicted branch
    tbl[0]  = alloc(5'd5, 1, 0, 0);
    tbl[1]  = alloc(5'd6, 1, 0, 0);
    tbl[2]  = alloc(5'd7, 1, 0, 0);
    tbl[3]  = cdb(3'd2, 32'h33, 0, 0);
    tbl[4]  = cdb(3'd0, 32'h11, 0, 0);
    tbl[5]  = cdb(3'd1, 32'h22, 1, 0);
    tbl[6]  = idle(1, 0, 0);
    tbl[7]  = idle(1, 0, 1);
    tbl[8]  = idle(0, 0, 1);
    tbl[9]  = mk(1, 5'd1, 1, 32'h100, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 3'd3, 32'h44, 1, 32'h100, 0, 0, 0);
    tbl[11] = idle(1, 0, 1);
    tbl[12] = idle(0, 0, 1);

    resetN               = 1'b0;
    bus.allocReq         = 1'b0;
    bus.allocDestReg     = '0;
    bus.allocIsControl   = 1'b0;
    bus.allocPredTarget  = '0;
    bus.cdbValid         = 1'b0;
    bus.cdbRobEntry      = '0;
    bus.cdbResult        = '0;
    bus.cdbIsControl     = 1'b0;
    bus.cdbTargetAddress = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    do_reset("init");
    chk("init redirectAddress", bus.redirectAddress, 32'd0);

    for (int i = 0; i < 13; i++) step(tbl[i], $sformatf("tbl%0d", i));

    // Stale broadcast to idle tag 5 must not make the later tag 5 ready
    step(cdb(3'd5, 32'hDEAD, 0, 1), "stale cdb");
    step(alloc(5'd9, 1, 0, 0), "stale a4");
    step(alloc(5'd0, 1, 0, 0), "stale a5");
    step(cdb(3'd4, 32'h40, 0, 0), "stale c4");
    step(idle(1, 0, 0), "stale r4");
    step(idle(0, 0, 0), "stale w1");
    step(idle(0, 0, 0), "stale w2");
    step(cdb(3'd5, 32'h55, 0, 0), "stale c5");
    step(idle(1, 0, 1), "stale r5");

    // Reset while a commit is on the outputs and entries are in flight
    step(alloc(5'd11, 1, 0, 0), "rst a6");
    step(alloc(5'd12, 1, 0, 0), "rst a7");
    step(mk(1, 5'd13, 0, 0, 1, 1, 3'd6, 32'h66, 0, 0, 0, 0, 0), "rst a0");
    step(idle(1, 0, 0), "rst r6");
    do_reset("midrun");

    // Fill to full, refuse while full even with a same-cycle commit, then wrap
    for (int i = 0; i < 8; i++) step(alloc(5'(i + 1), 1, 0, 0), $sformatf("fill%0d", i));
    chk("full after 8", 32'(bus.full), 32'd1);
    step(mk(1, 5'd20, 0, 0, 0, 1, 3'd0, 32'hF0, 0, 0, 0, 0, 0), "ninth req");
    step(alloc(5'd20, 0, 1, 0), "full with commit");
    chk("full after retire", 32'(bus.full), 32'd0);
    step(mk(1, 5'd21, 0, 0, 1, 1, 3'd1, 32'hF1, 0, 0, 0, 0, 0), "wrap tag0");
    chk("full after wrap", 32'(bus.full), 32'd1);
    step(mk(1, 5'd22, 0, 0, 0, 1, 3'd2, 32'hF2, 0, 0, 1, 0, 0), "full c1");
    step(alloc(5'd22, 1, 1, 0), "alloc+commit");
    chk("full after alloc+commit", 32'(bus.full), 32'd0);
    step(alloc(5'd23, 1, 0, 0), "refill");
    chk("full after refill", 32'(bus.full), 32'd1);
    do_reset("prewrap");

    // Mispredicted branch at tag 1; younger tags 2/3 must be discarded
    step(alloc(5'd2, 1, 0, 0), "mp a0");
    step(mk(1, 5'd31, 1, 32'h100, 1, 0, 0, 0, 0, 0, 0, 0, 0), "mp a1");
    step(mk(1, 5'd3, 0, 0, 1, 1, 3'd0, 32'hA0, 0, 0, 0, 0, 0), "mp a2");
    step(mk(1, 5'd4, 0, 0, 1, 1, 3'd1, 32'h1234, 1, 32'h200, 1, 0, 0), "mp a3");
    step(mk(1, 5'd9, 0, 0, 0, 1, 3'd2, 32'hC2, 0, 0, 1, 1, 1), "mp flush");
    chk("mp redirectAddress", bus.redirectAddress, 32'h200);
    step(idle(0, 0, 1), "mp after");
    chk("mp redirect held", bus.redirectAddress, 32'h200);
    chk("mp allocRob", 32'(bus.allocRob), 32'(exp_tail));
    step(idle(0, 0, 1), "mp quiet1");
    step(idle(0, 0, 1), "mp quiet2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
